// File: rtl/rom_vector_sequencer_pkg.sv
// rtl/rom_vector_sequencer_pkg.sv - shared types and defaults for the ROM vector sequencer
package rom_seq_pkg;

    localparam int DEF_W              = 32;
    localparam int ADDR_W             = 10;
    localparam int DEF_LAST_ADDR      = 1023;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Result word substituted when the CORDIC never answers: every bit set.
    localparam logic ERR_FILL = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_SEND     = 3'd4,
        S_NEXT     = 3'd5,
        S_DONE     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/rom_vector_sequencer_if.sv
// rtl/rom_vector_sequencer_if.sv - ROM, CORDIC and UART word signals of the sequencer
interface rom_vector_sequencer_if
    import rom_seq_pkg::*;
#(
    parameter int W = DEF_W
);
    logic [ADDR_W-1:0] address;
    logic [W-1:0]      rom_data;
    logic              beg_op;
    logic [W-1:0]      cordic_data;
    logic              cordic_ack;
    logic [W-1:0]      cordic_result;
    logic              tx_valid;
    logic [W-1:0]      tx_data;
    logic              tx_ready;

    modport master (
        output address, beg_op, cordic_data, tx_valid, tx_data,
        input  rom_data, cordic_ack, cordic_result, tx_ready
    );

    modport slave (
        input  address, beg_op, cordic_data, tx_valid, tx_data,
        output rom_data, cordic_ack, cordic_result, tx_ready
    );
endinterface

// File: rtl/rom_vector_sequencer_watchdog.sv
// rtl/rom_vector_sequencer_watchdog.sv - seq_watchdog: cycle counter that flags a stalled CORDIC wait
module seq_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // The last counted wait cycle is the expiry cycle, so the wait lasts exactly LIMIT cycles.
    assign expired = enable && (count == CW'(LIMIT - 1));

    // Count enabled cycles; clear on entry to the wait, hold once expired.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/rom_vector_sequencer.sv
// rtl/rom_vector_sequencer.sv - walks the vector ROM through the CORDIC and streams results; SEQ_TIMEOUT_EN adds a wait watchdog
module rom_vector_sequencer
    import rom_seq_pkg::*;
#(
    parameter int W              = DEF_W,
    parameter int LAST_ADDR      = DEF_LAST_ADDR,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    rom_vector_sequencer_if.master bus
);
    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [ADDR_W-1:0] address;
    logic              beg_op;
    logic [W-1:0]      cordic_data;
    logic              tx_valid;
    logic [W-1:0]      tx_data;
    logic              wd_expired;
    logic              last_vector;

    assign last_vector = (address == ADDR_W'(LAST_ADDR));

    assign bus.address     = address;
    assign bus.beg_op      = beg_op;
    assign bus.cordic_data = cordic_data;
    assign bus.tx_valid    = tx_valid;
    assign bus.tx_data     = tx_data;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; abort overrides every other transition, including ack and ready.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (start) state_nxt = S_FETCH;
                S_FETCH:    state_nxt = S_ISSUE;
                S_ISSUE:    state_nxt = S_WAIT_RES;
                S_WAIT_RES: if (bus.cordic_ack || wd_expired) state_nxt = S_SEND;
                S_SEND:     if (bus.tx_ready) state_nxt = S_NEXT;
                S_NEXT:     state_nxt = last_vector ? S_DONE : S_FETCH;
                S_DONE:     state_nxt = S_IDLE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    // Registered outputs and datapath; strobes are decoded from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            address     <= '0;
            beg_op      <= 1'b0;
            cordic_data <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            beg_op   <= (state_nxt == S_ISSUE);
            tx_valid <= (state_nxt == S_SEND);
            done     <= (state_nxt == S_DONE);
            busy     <= (state_nxt != S_IDLE);

            if (abort || state == S_DONE) begin
                address <= '0;
            end else if (state == S_NEXT && !last_vector) begin
                address <= address + 1'b1;
            end

            if (!abort && state == S_FETCH) begin
                cordic_data <= bus.rom_data;
            end

            // A result arriving with abort is dropped; ack beats a same-cycle timeout.
            if (!abort && state == S_WAIT_RES) begin
                if (bus.cordic_ack) begin
                    tx_data <= bus.cordic_result;
                end else if (wd_expired) begin
                    tx_data <= {W{ERR_FILL}};
                end
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;
    logic err_q;

    assign wd_clear  = (state_nxt == S_WAIT_RES) && (state != S_WAIT_RES);
    assign wd_enable = (state == S_WAIT_RES);
    assign err       = err_q;

    seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Sticky timeout flag; only a fresh accepted start clears it, abort does not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (!abort && state == S_IDLE && start) begin
            err_q <= 1'b0;
        end else if (!abort && state == S_WAIT_RES && !bus.cordic_ack && wd_expired) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign wd_expired     = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_rom_vector_sequencer.sv
// tb/tb_rom_vector_sequencer.sv - directed self-checking bench for rom_vector_sequencer
module tb_rom_vector_sequencer;
    localparam int W = 32;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [31:0] TO_EN = 32'd1;
`else
    localparam logic [31:0] TO_EN = 32'd0;
`endif

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic done;
    logic err;

    bit   ack_en   = 1'b0;
    logic seen_beg = 1'b0;

    int checks = 0;
    int errors = 0;

    rom_vector_sequencer_if #(.W(W)) bus ();

    rom_vector_sequencer #(
        .W              (W),
        .LAST_ADDR      (7),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = 32'h100 + 32'(bus.address);

    always begin
        @(posedge clk);
        #1;
        bus.cordic_ack    = ack_en && seen_beg;
        bus.cordic_result = bus.cordic_data;
        seen_beg          = bus.beg_op;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    int          first_beg;
    int          first_val;
    int          done_cnt;
    int          done_cyc;
    int          n;
    int          stable;
    bit          found;
    logic [31:0] d0;
    logic [31:0] a0;
    logic [31:0] got_q[$];

    initial begin
        bus.tx_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_address", 32'(bus.address), 32'd0);
        check("rst_beg_op", 32'(bus.beg_op), 32'd0);
        check("rst_cordic_data", bus.cordic_data, 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", bus.tx_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // full run, immediate ack and ready
        ack_en       = 1'b1;
        bus.tx_ready = 1'b1;
        first_beg = -1; first_val = -1; done_cnt = 0; done_cyc = -1;
        pulse_start();
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) check("run_busy_c1", 32'(busy), 32'd1);
            if (bus.beg_op && first_beg < 0) first_beg = c;
            if (bus.tx_valid) begin
                if (first_val < 0) first_val = c;
                got_q.push_back(bus.tx_data);
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        check("run_first_beg_op", first_beg, 32'd2);
        check("run_first_tx_valid", first_val, 32'd4);
        check("run_word_count", got_q.size(), 32'd8);
        for (int i = 0; i < got_q.size(); i++) check("run_word", got_q[i], 32'h100 + 32'(i));
        check("run_done_count", done_cnt, 32'd1);
        check("run_done_cycle", done_cyc, 32'd41);
        check("run_idle_busy", 32'(busy), 32'd0);
        check("run_idle_address", 32'(bus.address), 32'd0);

        // tx_ready held low in SEND
        bus.tx_ready = 1'b0;
        pulse_start();
        n = 0;
        while (!bus.tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid", 32'(bus.tx_valid), 32'd1);
        d0 = bus.tx_data;
        a0 = 32'(bus.address);
        check("hold_word", d0, 32'h100);
        check("hold_addr", a0, 32'd0);
        stable = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.tx_valid && bus.tx_data == d0 && 32'(bus.address) == a0) stable++;
        end
        check("hold_stable_cycles", stable, 32'd10);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        check("hold_release", 32'(bus.tx_valid), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("hold_abort_busy", 32'(busy), 32'd0);

        // start during WAIT_RES, then CORDIC silence
        ack_en = 1'b0;
        pulse_start();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("wait_start_addr", 32'(bus.address), 32'd0);
        check("wait_start_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("wait_start_no_issue", 32'(bus.beg_op), 32'd0);
        repeat (4) @(negedge clk);
        check("wait_c10_no_valid", 32'(bus.tx_valid), 32'd0);
        @(negedge clk);
`ifdef SEQ_TIMEOUT_EN
        check("timeout_valid", 32'(bus.tx_valid), 32'd1);
        check("timeout_word", bus.tx_data, 32'hFFFF_FFFF);
        check("timeout_err", 32'(err), 32'd1);
`else
        check("no_timeout_valid", 32'(bus.tx_valid), 32'd0);
        check("no_timeout_err", 32'(err), 32'd0);
        check("no_timeout_busy", 32'(busy), 32'd1);
`endif
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("err_after_abort", 32'(err), TO_EN);
        check("abort_busy", 32'(busy), 32'd0);
        pulse_start();
        @(negedge clk);
        check("err_cleared_by_start", 32'(err), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", 32'(busy), 32'd0);

        // abort coinciding with ack at address 7
        ack_en       = 1'b1;
        bus.tx_ready = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.address == 10'd7 && bus.cordic_ack) begin
                abort = 1'b1;
                found = 1'b1;
                break;
            end
        end
        check("abort_ack_reached", 32'(found), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_ack_no_valid", 32'(bus.tx_valid), 32'd0);
        check("abort_ack_busy", 32'(busy), 32'd0);
        check("abort_ack_addr", 32'(bus.address), 32'd0);
        check("abort_ack_no_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_ack_stays_idle", 32'(bus.tx_valid) | 32'(busy), 32'd0);

        // asynchronous reset in SEND at address 5
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.address == 10'd5) bus.tx_ready = 1'b0;
            if (bus.address == 10'd5 && bus.tx_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_send_reached", 32'(found), 32'd1);
        check("mid_send_word", bus.tx_data, 32'h105);
        rst = 1'b0;
        #1;
        check("arst_address", 32'(bus.address), 32'd0);
        check("arst_beg_op", 32'(bus.beg_op), 32'd0);
        check("arst_cordic_data", bus.cordic_data, 32'd0);
        check("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("arst_tx_data", bus.tx_data, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        check("arst_stays_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/rom_vector_sequencer.md
# rom_vector_sequencer

Sequences the 1024-entry test-vector ROM through the CORDIC natural-logarithm core and streams each result word to the UART transmit path. Drives the ROM address, registers the returned operand, launches one CORDIC operation per vector, waits for completion, then hands the result word to the UART word sender with a valid/ready handshake. It sits between the test ROM and the CORDIC and UART blocks in the hardware test harness.

## Interface
- W, 32, data width of ROM words, CORDIC operand/result and UART word
- LAST_ADDR, 1023, final ROM address processed (0..1023)
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT_RES (only with SEQ_TIMEOUT_EN)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- start  in  1  one-cycle pulse; begins a run from address 0; ignored unless IDLE
- abort  in  1  synchronous; returns to IDLE from any state next cycle, address to 0
- address  out  10  ROM address
- rom_data  in  W  combinational ROM read data for `address`
- beg_op  out  1  one-cycle CORDIC start pulse
- cordic_data  out  W  registered operand, stable from ISSUE until next FETCH
- cordic_ack  in  1  CORDIC result valid, sampled only in WAIT_RES
- cordic_result  in  W  CORDIC result, captured when cordic_ack=1 in WAIT_RES
- tx_valid  out  1  result word available to UART sender
- tx_data  out  W  result word, stable while tx_valid=1
- tx_ready  in  1  UART sender accepts word when tx_valid && tx_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last vector sent
- err  out  1  sticky timeout flag (constant 0 without SEQ_TIMEOUT_EN)

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_RES, SEND, NEXT, DONE.
- IDLE: address=0; start -> FETCH.
- FETCH (1 cycle): cordic_data <= rom_data -> ISSUE.
- ISSUE (1 cycle): beg_op=1 -> WAIT_RES.
- WAIT_RES: cordic_ack=1 -> tx_data <= cordic_result, -> SEND.
- SEND: tx_valid=1; on tx_ready -> NEXT; tx_data/tx_valid hold otherwise.
- NEXT (1 cycle): address==LAST_ADDR -> DONE; else address+1 -> FETCH. No wrap past LAST_ADDR.
- DONE (1 cycle): done=1, address <= 0 -> IDLE.
- abort has priority over all transitions, including simultaneous cordic_ack or tx_ready; a captured result is discarded; err is not cleared.
- start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
- err clears only on reset or on start accepted in IDLE.

## Timing
- Reset values: address=0, beg_op=0, cordic_data=0, tx_valid=0, tx_data=0, busy=0, done=0, err=0, state IDLE.
- start at cycle 0 -> FETCH at 1, beg_op at 2, earliest ack sampled at 3, tx_valid at 4.
- Minimum 5 cycles per vector (ack and tx_ready immediate); full 1024-vector run 5120 cycles + DONE.
- cordic_ack during ISSUE is ignored; CORDIC must not acknowledge in the beg_op cycle.
- All outputs registered; no combinational input-to-output path except none (address is a register).

## Configuration
- SEQ_TIMEOUT_EN defined: cycle counter runs in WAIT_RES, cleared on entry; reaching TIMEOUT_CYCLES without cordic_ack sets err, loads tx_data with all-ones, -> SEND; run continues.
- Undefined: no counter, WAIT_RES waits indefinitely, err tied 0, TIMEOUT_CYCLES unused.

## Structure
- Shared package rom_seq_pkg: state encoding constants, LAST_ADDR default, TIMEOUT_CYCLES default, error word definition.
- One sub-module: seq_watchdog (load/clear, enable, count, expired flag), instantiated only under SEQ_TIMEOUT_EN.

## Test plan
- Reset mid-SEND at address 5 -> all outputs reset values immediately, state IDLE, address=0.
- LAST_ADDR=3, ROM[i]=i+0x100, CORDIC model echoes operand next cycle, tx_ready=1 -> tx_data sequence 0x100,0x101,0x102,0x103, done pulse once, 20+1 cycles.
- tx_ready held 0 for 10 cycles in SEND -> tx_valid and tx_data stable 10 cycles, address unchanged.
- abort asserted same cycle as cordic_ack at address 7 -> no tx_valid, IDLE next cycle, address=0.
- start pulsed during WAIT_RES -> no effect, address and state unchanged.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> err=1, tx_data=0xFFFFFFFF after 8 cycles; next start clears err.
